// File: rtl/mem_initiator.sv
// Single-outstanding memory bus initiator: accepts one command, issues a one-cycle
// strobe, captures the memory response and counts completions and error codes.
module mem_initiator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [9:0]       cmd_addr,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_write,
  output logic [31:0]      rsp_rdata,
  output logic [1:0]       rsp_err,
  output logic [9:0]       addr,
  output logic             wr_en,
  output logic             rd_en,
  output logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  input  logic [1:0]       err_rsp,
  output logic [CNT_W-1:0] cnt_decode,
  output logic [CNT_W-1:0] cnt_slave,
  output logic [CNT_W-1:0] cnt_reserved,
  output logic [15:0]      txn_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state_r, state_s;
  logic   write_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // State register; cmd_ready is registered from the next state so it is high exactly in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cmd_ready <= 1'b1;
    end else begin
      state_r   <= state_s;
      cmd_ready <= (state_s == IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) state_s = ISSUE;
        else           state_s = IDLE;
      end
      ISSUE:   state_s = CAPTURE;
      CAPTURE: state_s = RESP;
      RESP: begin
        if (rsp_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Bus side: strobes live only in ISSUE, addr/wdata only in ISSUE and CAPTURE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr    <= 10'd0;
      wdata   <= 32'd0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      write_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            addr    <= cmd_addr;
            wr_en   <= cmd_write;
            rd_en   <= !cmd_write;
            wdata   <= cmd_write ? cmd_wdata : 32'd0;
            write_r <= cmd_write;
          end else begin
            addr  <= 10'd0;
            wdata <= 32'd0;
            wr_en <= 1'b0;
            rd_en <= 1'b0;
          end
        end
        ISSUE: begin
          wr_en <= 1'b0;
          rd_en <= 1'b0;
        end
        default: begin
          addr  <= 10'd0;
          wdata <= 32'd0;
          wr_en <= 1'b0;
          rd_en <= 1'b0;
        end
      endcase
    end
  end

  // Response capture and statistics; the response is held until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid    <= 1'b0;
      rsp_write    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 2'b00;
      txn_cnt      <= 16'd0;
      cnt_decode   <= {CNT_W{1'b0}};
      cnt_slave    <= {CNT_W{1'b0}};
      cnt_reserved <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_write <= write_r;
          rsp_err   <= err_rsp;
          rsp_rdata <= write_r ? 32'd0 : rdata;
          txn_cnt   <= txn_cnt + 16'd1;
          case (err_rsp)
            2'b01:   cnt_decode   <= sat_inc(cnt_decode);
            2'b10:   cnt_slave    <= sat_inc(cnt_slave);
            2'b11:   cnt_reserved <= sat_inc(cnt_reserved);
            default: ;
          endcase
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: a behavioural memory on the bus, a transaction-level
// reference model, directed scenarios followed by randomized traffic.
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_write, rsp_ready;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata, rdata;
  logic [1:0]  err_rsp;

  logic        cmd_ready, rsp_valid, rsp_write, wr_en, rd_en;
  logic [31:0] rsp_rdata, wdata;
  logic [1:0]  rsp_err;
  logic [9:0]  addr;
  logic [1:0]  cnt_decode, cnt_slave, cnt_reserved;
  logic [15:0] txn_cnt;

  logic        d_cmd_ready, d_rsp_valid, d_rsp_write, d_wr_en, d_rd_en;
  logic [31:0] d_rsp_rdata, d_wdata;
  logic [1:0]  d_rsp_err;
  logic [9:0]  d_addr;
  logic [7:0]  d_cnt_decode, d_cnt_slave, d_cnt_reserved;
  logic [15:0] d_txn_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] bus_mem [1024];
  logic [31:0] ref_mem [1024];
  int m_dec, m_sl, m_res, m_txn;

  mem_initiator #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .addr(addr), .wr_en(wr_en),
    .rd_en(rd_en), .wdata(wdata), .rdata(rdata), .err_rsp(err_rsp),
    .cnt_decode(cnt_decode), .cnt_slave(cnt_slave), .cnt_reserved(cnt_reserved),
    .txn_cnt(txn_cnt)
  );

  mem_initiator u_def (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(d_cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(d_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(d_rsp_write),
    .rsp_rdata(d_rsp_rdata), .rsp_err(d_rsp_err), .addr(d_addr), .wr_en(d_wr_en),
    .rd_en(d_rd_en), .wdata(d_wdata), .rdata(rdata), .err_rsp(err_rsp),
    .cnt_decode(d_cnt_decode), .cnt_slave(d_cnt_slave), .cnt_reserved(d_cnt_reserved),
    .txn_cnt(d_txn_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit is_res(input logic [9:0] a);
    return (a >= 10'd61) && (a <= 10'd64);
  endfunction

  function automatic bit is_bad(input logic [9:0] a);
    return (a >= 10'd100) && (a <= 10'd255);
  endfunction

  // Memory map: 61..64 reserved, 100..255 decode-error on write / slave-error on read.
  function automatic logic [1:0] bus_err(input logic w, input logic [9:0] a);
    if (is_res(a)) return 2'b11;
    else if (is_bad(a)) return w ? 2'b01 : 2'b10;
    else return 2'b00;
  endfunction

  // Behavioural memory: registered one-cycle response to a strobe.
  always @(posedge clk) begin
    if (rd_en) begin
      err_rsp <= bus_err(1'b0, addr);
      rdata   <= is_res(addr) ? 32'hDEAD_BEEF : (is_bad(addr) ? (32'h0BAD_0000 | 32'(addr)) : bus_mem[addr]);
    end else if (wr_en) begin
      err_rsp <= bus_err(1'b1, addr);
      rdata   <= 32'hDEAD_BEEF;
      if (bus_err(1'b1, addr) == 2'b00) bus_mem[addr] <= wdata;
    end else begin
      err_rsp <= 2'b00;
      rdata   <= 32'd0;
    end
  end

  function automatic int sat(input int m, input int mx);
    return (m > mx) ? mx : m;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts();
    check("cnt_decode",     64'(cnt_decode),     64'(sat(m_dec, 3)));
    check("cnt_slave",      64'(cnt_slave),      64'(sat(m_sl, 3)));
    check("cnt_reserved",   64'(cnt_reserved),   64'(sat(m_res, 3)));
    check("txn_cnt",        64'(txn_cnt),        64'(m_txn % 65536));
    check("d_cnt_decode",   64'(d_cnt_decode),   64'(sat(m_dec, 255)));
    check("d_cnt_slave",    64'(d_cnt_slave),    64'(sat(m_sl, 255)));
    check("d_cnt_reserved", 64'(d_cnt_reserved), 64'(sat(m_res, 255)));
    check("d_txn_cnt",      64'(d_txn_cnt),      64'(m_txn % 65536));
  endtask

  // One complete transaction; entered and left at #1 after an edge with the block idle.
  task automatic do_txn(input logic w, input logic [9:0] a, input logic [31:0] d, input int hold);
    logic [1:0]  e_err;
    logic [31:0] e_rd;
    e_err = bus_err(w, a);
    if (w) e_rd = 32'd0;
    else if (is_res(a)) e_rd = 32'hDEAD_BEEF;
    else if (is_bad(a)) e_rd = 32'h0BAD_0000 | 32'(a);
    else e_rd = ref_mem[a];
    if (w && e_err == 2'b00) ref_mem[a] = d;
    m_txn++;
    if (e_err == 2'b01) m_dec++;
    if (e_err == 2'b10) m_sl++;
    if (e_err == 2'b11) m_res++;

    check("ready_before_accept", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    tick();
    check("e0_wr_en", 64'(wr_en), 64'(w));
    check("e0_rd_en", 64'(rd_en), 64'(!w));
    check("e0_addr",  64'(addr),  64'(a));
    check("e0_wdata", 64'(wdata), w ? 64'(d) : 64'(0));
    check("e0_ready", 64'(cmd_ready), 64'(0));
    check("d_e0_addr", 64'(d_addr), 64'(a));
    cmd_valid = 1'($urandom_range(0, 1)); cmd_write = ~w;
    cmd_addr = 10'($urandom); cmd_wdata = $urandom;
    tick();
    check("e1_strobes", 64'({wr_en, rd_en, d_wr_en, d_rd_en}), 64'(0));
    check("e1_addr",  64'(addr),  64'(a));
    check("e1_wdata", 64'(wdata), w ? 64'(d) : 64'(0));
    tick();
    check("rsp_valid", 64'(rsp_valid), 64'(1));
    check("rsp_write", 64'(rsp_write), 64'(w));
    check("rsp_err",   64'(rsp_err),   64'(e_err));
    check("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
    check("d_rsp",     64'({d_rsp_valid, d_rsp_write, d_rsp_err}), 64'({1'b1, w, e_err}));
    check("d_rsp_rdata", 64'(d_rsp_rdata), 64'(e_rd));
    check("resp_bus_idle", 64'({addr, wdata, d_addr, d_wdata}), 64'(0));
    check_counts();
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'($urandom_range(0, 1)); cmd_addr = 10'($urandom);
      tick();
      check("hold_valid", 64'(rsp_valid), 64'(1));
      check("hold_rsp",   64'({rsp_write, rsp_err, rsp_rdata}), 64'({w, e_err, e_rd}));
      check("hold_ready", 64'({cmd_ready, d_cmd_ready}), 64'(0));
    end
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'd7;
    tick();
    check("post_hs_valid", 64'({rsp_valid, d_rsp_valid}), 64'(0));
    check("post_hs_ready", 64'({cmd_ready, d_cmd_ready}), 64'(3));
    check("post_hs_no_accept", 64'({wr_en, rd_en, addr}), 64'(0));
    rsp_ready = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bus_mem[i] = 32'hFFFF_FFFF;
      ref_mem[i] = 32'hFFFF_FFFF;
    end
    m_dec = 0; m_sl = 0; m_res = 0; m_txn = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 10'd0;
    cmd_wdata = 32'd0; rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_ready", 64'({cmd_ready, d_cmd_ready}), 64'(3));
    check("rst_rsp",   64'({rsp_valid, rsp_write, rsp_err, rsp_rdata}), 64'(0));
    check("rst_bus",   64'({addr, wr_en, rd_en, wdata}), 64'(0));
    check_counts();
    reset = 1'b0;

    // Write then read back a normal location.
    do_txn(1'b1, 10'd5, 32'hA5A5_0001, 0);
    do_txn(1'b0, 10'd5, 32'd0, 1);
    check("basic_txn_cnt", 64'(txn_cnt), 64'(2));
    // Decode and slave errors.
    do_txn(1'b1, 10'd100, 32'h1234_5678, 0);
    do_txn(1'b0, 10'd100, 32'd0, 0);
    check("err_dec_slv", 64'({cnt_decode, cnt_slave}), 64'({2'd1, 2'd1}));
    // Reserved window.
    do_txn(1'b0, 10'd62, 32'd0, 0);
    do_txn(1'b1, 10'd61, 32'h5555_AAAA, 0);
    check("err_res", 64'(cnt_reserved), 64'(2));
    // Long backpressure.
    do_txn(1'b0, 10'd5, 32'd0, 10);

    // Reset during CAPTURE of a read discards it.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'd7;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    m_dec = 0; m_sl = 0; m_res = 0; m_txn = 0;
    check("mid_rst_bus",   64'({rd_en, wr_en, addr, d_rd_en}), 64'(0));
    check("mid_rst_valid", 64'({rsp_valid, d_rsp_valid}), 64'(0));
    check("mid_rst_ready", 64'(cmd_ready), 64'(1));
    check_counts();
    tick();
    tick();
    check("rst_hold_valid", 64'(rsp_valid), 64'(0));
    reset = 1'b0;
    check("after_rst_txn", 64'(txn_cnt), 64'(0));
    do_txn(1'b0, 10'd0, 32'd0, 2);

    // Saturation of the 2-bit slave counter.
    repeat (5) do_txn(1'b0, 10'd200, 32'd0, 0);
    check("sat_slave",   64'(cnt_slave),   64'(3));
    check("d_nosat_slave", 64'(d_cnt_slave), 64'(5));

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic [9:0] a;
      int pick;
      pick = int'($urandom_range(0, 3));
      case (pick)
        0: a = 10'($urandom_range(0, 15));
        1: a = 10'($urandom_range(61, 64));
        2: a = 10'($urandom_range(100, 255));
        default: a = 10'($urandom);
      endcase
      do_txn(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
      repeat (int'($urandom_range(0, 2))) begin
        tick();
        check("gap_idle", 64'({cmd_ready, rsp_valid, wr_en, rd_en, addr}), 64'({1'b1, 13'd0}));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
